control_stage3_occ_fetch: RTL and testbench
===========================================

Name: control_stage3_occ_fetch

Overview:
- Sits directly downstream of the backward-extension control stage (stage 2).
- Takes stage-2 tokens and issues one in-order occurrence-line memory request for every BCK_RUN token.
- Holds tokens in an in-order buffer until their 512-bit line returns, then hands token plus line to the occurrence-compute stage.
- Back-pressures stage 2 through its stall input.

Parameters:
DEPTH, 8, token buffer entries (power of 2, ≥2)
PTR_W, 3, log2(DEPTH)

Ports:
clk  in  1  clock
rst  in  1  reset
status_q  in  6  stage-2 token status (BUBBLE=0, BCK_INI=6'b001000, BCK_RUN=6'b010000, BCK_END=6'b100000, F_*=low bits)
read_num_q  in  9  read index
backward_i_q  in  7  backward i
backward_j_q  in  7  backward j
current_rd_addr_q  in  7  stage-2 read address
primary_q  in  64  interval start k
finish_sign_q  in  1  finish flag
iteration_boundary_q  in  1  iteration boundary flag
mem_base  in  64  occurrence table base (static during run)
stall_out  out  1  to stage-2 stall input
req_valid  out  1  memory request valid
req_ready  in  1  memory accepts request
req_addr  out  64  line address
rsp_valid  in  1  response beat, in request order
rsp_data  in  512  occurrence line (CL bits)
out_stall  in  1  downstream stall
out_valid  out  1  output token valid
out_status, out_read_num, out_backward_i, out_backward_j, out_rd_addr, out_primary, out_finish_sign, out_iteration_boundary  out  6/9/7/7/7/64/1/1  registered token fields
out_occ_line  out  512  fetched line (0 for non-fetch tokens)
err_orphan_rsp  out  1  sticky: response with no outstanding request

Behaviour:
- Single clock domain: clk. Reset: rst, asynchronous, active-high.
- While rst is high, or on its assertion mid-operation:
  - all outputs are 0; out_status=BUBBLE.
  - buffer, all pointers and err_orphan_rsp are cleared.
  - in-flight requests are abandoned; a memory system that can deliver responses after reset must be reset too.
- Enqueue occurs when status_q!=0 and !stall_out.
  - BUBBLE tokens are dropped and never enqueued.
  - stall_out = (count==DEPTH), driven from registers only.
  - While full, stage 2 holds its token and it is not captured twice.
- Per-entry state:
  - token fields.
  - need = (status_q==BCK_RUN).
  - addr = mem_base + {7'b0, primary_q[63:7]}, modulo 2^64.
  - done = !need.
  - line = 0.
- Request pointer walks entries in order and skips entries with need=0.
  - req_valid is high while the pointer addresses an un-requested need entry.
  - Pointer advances on req_valid & req_ready.
  - req_addr is held stable while req_valid & !req_ready.
- Response pointer walks need entries in order.
  - rsp_valid writes rsp_data into that entry, sets done and advances the pointer.
  - rsp_valid with zero outstanding requests is ignored and sets err_orphan_rsp.
- Output register:
  - Loads the head entry when head.done and (!out_valid or !out_stall); head pops on load.
  - When out_valid is high and out_stall is high, all out_* hold.
  - When no entry is ready and !out_stall, out_valid=0 and out_status=BUBBLE.
- Latency:
  - Non-fetch token: enqueued at edge N, visible at out_* after edge N+1.
  - Fetch token: rsp at edge M → visible after edge M+1 (if at head).
- Order: tokens leave in arrival order; a non-fetch token waits behind an earlier pending fetch.
- Simultaneous enqueue and pop when full: no enqueue that cycle, because stall_out was high.
- Simultaneous enqueue and pop otherwise: count unchanged.
- Pointers wrap modulo DEPTH.

Optional Feature:
- PERF_CNT_EN defined:
  - Adds 32-bit outputs perf_stall_cycles (cycles with stall_out=1) and perf_fetches (req handshakes).
  - Both saturate at 0xFFFFFFFF and are cleared by rst.
- Undefined: the same ports exist and are tied to 0; no counter logic.

Test Plan:
- One BCK_INI token, read_num_q=5 → out_valid after 2 edges, out_status=6'b001000, out_occ_line=0, req_valid never high.
- BCK_RUN, primary_q=64'h1_0080, mem_base=64'h1000 → req_addr=64'h1201; rsp_data=512'hA5.. returned 3 cycles later → out_occ_line=rsp_data, out_primary=64'h1_0080.
- Fill DEPTH=8 BCK_RUN tokens with req_ready=0 → stall_out=1 after the 8th; 9th token is held and enqueued exactly once after the first pop.
- Sequence RUN, INI, RUN with responses delayed → outputs appear in order RUN, INI, RUN; INI waits for the first RUN's response.
- out_stall=1 for 5 cycles with a token at out_* → all out_* stable; rsp_valid with no request outstanding → err_orphan_rsp=1 and stays set.
- Assert rst with 3 tokens buffered and 2 requests outstanding → all outputs 0 immediately; after release, a new BCK_INI passes normally.

Source files
------------

// File: rtl/control_stage3_occ_fetch.sv
// rtl/control_stage3_occ_fetch.sv - stage-3 occurrence-line fetch with in-order token buffer
//
// Purpose:
//    Accepts stage-2 tokens, drops bubbles, and holds the rest in an in-order
//    buffer. Each BCK_RUN token issues one occurrence-line memory request.
//    Tokens leave in arrival order, each paired with its 512-bit line. Tokens
//    that fetch nothing carry a zero line. Stage 2 is stalled while the
//    buffer is full.
//
// Ports:
//    clk, rst              clock, asynchronous active-high reset
//    status_q .. iteration_boundary_q   stage-2 token fields
//    mem_base              occurrence table base address (static)
//    stall_out             stall to stage 2 (buffer full), registered
//    req_valid/ready/addr  in-order line request channel
//    rsp_valid/data        in-order line response channel
//    out_stall             downstream stall
//    out_*                 registered output token, out_occ_line = fetched line
//    err_orphan_rsp        sticky: response seen with nothing outstanding
//    perf_stall_cycles     stall_out cycle count      (PERF_CNT_EN, else 0)
//    perf_fetches          request handshake count    (PERF_CNT_EN, else 0)
//
// Configuration macro: PERF_CNT_EN enables the saturating performance counters.

module control_stage3_occ_fetch #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [5:0]   status_q,
   input  logic [8:0]   read_num_q,
   input  logic [6:0]   backward_i_q,
   input  logic [6:0]   backward_j_q,
   input  logic [6:0]   current_rd_addr_q,
   input  logic [63:0]  primary_q,
   input  logic         finish_sign_q,
   input  logic         iteration_boundary_q,
   input  logic [63:0]  mem_base,
   output logic         stall_out,
   output logic         req_valid,
   input  logic         req_ready,
   output logic [63:0]  req_addr,
   input  logic         rsp_valid,
   input  logic [511:0] rsp_data,
   input  logic         out_stall,
   output logic         out_valid,
   output logic [5:0]   out_status,
   output logic [8:0]   out_read_num,
   output logic [6:0]   out_backward_i,
   output logic [6:0]   out_backward_j,
   output logic [6:0]   out_rd_addr,
   output logic [63:0]  out_primary,
   output logic         out_finish_sign,
   output logic         out_iteration_boundary,
   output logic [511:0] out_occ_line,
   output logic         err_orphan_rsp,
   output logic [31:0]  perf_stall_cycles,
   output logic [31:0]  perf_fetches
);

   localparam logic [5:0]   ST_BUBBLE  = 6'b000000;
   localparam logic [5:0]   ST_BCK_RUN = 6'b010000;
   localparam logic [PTR_W:0] PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [PTR_W:0] DEPTH_W  = DEPTH[PTR_W:0];

   // token buffer storage
   logic [5:0]   e_status   [DEPTH];
   logic [8:0]   e_read_num [DEPTH];
   logic [6:0]   e_bi       [DEPTH];
   logic [6:0]   e_bj       [DEPTH];
   logic [6:0]   e_rd       [DEPTH];
   logic [63:0]  e_primary  [DEPTH];
   logic [63:0]  e_addr     [DEPTH];
   logic [511:0] e_line     [DEPTH];
   logic [DEPTH-1:0] e_fin;
   logic [DEPTH-1:0] e_ib;
   logic [DEPTH-1:0] e_need;
   logic [DEPTH-1:0] e_done;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] hd_ptr;
   logic [PTR_W:0] rq_ptr;
   logic           full_q;

   // Indices of requested entries, in request order; the head of this list is
   // the entry the next response belongs to.
   logic [PTR_W-1:0] idx_fifo [DEPTH];
   logic [PTR_W:0]   ix_wr;
   logic [PTR_W:0]   ix_rd;

   logic [PTR_W-1:0] wr_idx;
   logic [PTR_W-1:0] hd_idx;
   logic [PTR_W-1:0] rq_idx;
   logic [PTR_W-1:0] rsp_idx;
   logic [PTR_W:0]   count;
   logic [PTR_W:0]   count_nxt;
   logic [PTR_W:0]   outstanding;
   logic             enq;
   logic             rq_has;
   logic             rq_adv;
   logic             req_fire;
   logic             rsp_ok;
   logic             hd_has;
   logic             load;

   assign wr_idx      = wr_ptr[PTR_W-1:0];
   assign hd_idx      = hd_ptr[PTR_W-1:0];
   assign rq_idx      = rq_ptr[PTR_W-1:0];
   assign rsp_idx     = idx_fifo[ix_rd[PTR_W-1:0]];
   assign count       = wr_ptr - hd_ptr;
   assign outstanding = ix_wr - ix_rd;

   assign stall_out = full_q;
   assign enq       = (status_q != ST_BUBBLE) && !full_q;

   // The request pointer never falls behind the head: it steps over a
   // non-fetch entry in the same cycle the head could pop it, and a fetch
   // entry cannot pop before it has been requested and answered.
   assign rq_has    = (rq_ptr != wr_ptr);
   assign req_valid = rq_has && e_need[rq_idx];
   assign req_addr  = req_valid ? e_addr[rq_idx] : 64'd0;
   assign req_fire  = req_valid && req_ready;
   assign rq_adv    = rq_has && (!e_need[rq_idx] || req_ready);

   assign rsp_ok    = rsp_valid && (outstanding != '0);

   assign hd_has    = (hd_ptr != wr_ptr);
   assign load      = hd_has && e_done[hd_idx] && (!out_valid || !out_stall);

   always_comb begin
      count_nxt = count;
      if (enq)  count_nxt = count_nxt + PTR_ONE;
      if (load) count_nxt = count_nxt - PTR_ONE;
   end

   // buffer, pointers and request bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr         <= '0;
         hd_ptr         <= '0;
         rq_ptr         <= '0;
         ix_wr          <= '0;
         ix_rd          <= '0;
         full_q         <= 1'b0;
         err_orphan_rsp <= 1'b0;
         e_fin          <= '0;
         e_ib           <= '0;
         e_need         <= '0;
         e_done         <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            e_status[i]   <= '0;
            e_read_num[i] <= '0;
            e_bi[i]       <= '0;
            e_bj[i]       <= '0;
            e_rd[i]       <= '0;
            e_primary[i]  <= '0;
            e_addr[i]     <= '0;
            e_line[i]     <= '0;
            idx_fifo[i]   <= '0;
         end
      end else begin
         if (enq) begin
            e_status[wr_idx]   <= status_q;
            e_read_num[wr_idx] <= read_num_q;
            e_bi[wr_idx]       <= backward_i_q;
            e_bj[wr_idx]       <= backward_j_q;
            e_rd[wr_idx]       <= current_rd_addr_q;
            e_primary[wr_idx]  <= primary_q;
            e_fin[wr_idx]      <= finish_sign_q;
            e_ib[wr_idx]       <= iteration_boundary_q;
            e_need[wr_idx]     <= (status_q == ST_BCK_RUN);
            e_done[wr_idx]     <= (status_q != ST_BCK_RUN);
            e_addr[wr_idx]     <= mem_base + {7'b0, primary_q[63:7]};
            e_line[wr_idx]     <= '0;
            wr_ptr             <= wr_ptr + PTR_ONE;
         end
         if (rq_adv) begin
            rq_ptr <= rq_ptr + PTR_ONE;
         end
         if (req_fire) begin
            idx_fifo[ix_wr[PTR_W-1:0]] <= rq_idx;
            ix_wr                      <= ix_wr + PTR_ONE;
         end
         // The enqueue slot is always free, so it never collides with the
         // live entry a response lands in.
         if (rsp_ok) begin
            e_line[rsp_idx] <= rsp_data;
            e_done[rsp_idx] <= 1'b1;
            ix_rd           <= ix_rd + PTR_ONE;
         end
         if (rsp_valid && (outstanding == '0)) begin
            err_orphan_rsp <= 1'b1;
         end
         if (load) begin
            hd_ptr <= hd_ptr + PTR_ONE;
         end
         full_q <= (count_nxt == DEPTH_W);
      end
   end

   // output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid              <= 1'b0;
         out_status             <= ST_BUBBLE;
         out_read_num           <= '0;
         out_backward_i         <= '0;
         out_backward_j         <= '0;
         out_rd_addr            <= '0;
         out_primary            <= '0;
         out_finish_sign        <= 1'b0;
         out_iteration_boundary <= 1'b0;
         out_occ_line           <= '0;
      end else if (load) begin
         out_valid              <= 1'b1;
         out_status             <= e_status[hd_idx];
         out_read_num           <= e_read_num[hd_idx];
         out_backward_i         <= e_bi[hd_idx];
         out_backward_j         <= e_bj[hd_idx];
         out_rd_addr            <= e_rd[hd_idx];
         out_primary            <= e_primary[hd_idx];
         out_finish_sign        <= e_fin[hd_idx];
         out_iteration_boundary <= e_ib[hd_idx];
         out_occ_line           <= e_line[hd_idx];
      end else if (!out_valid || !out_stall) begin
         out_valid              <= 1'b0;
         out_status             <= ST_BUBBLE;
         out_read_num           <= '0;
         out_backward_i         <= '0;
         out_backward_j         <= '0;
         out_rd_addr            <= '0;
         out_primary            <= '0;
         out_finish_sign        <= 1'b0;
         out_iteration_boundary <= 1'b0;
         out_occ_line           <= '0;
      end
   end

`ifdef PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] fetch_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         fetch_cnt <= '0;
      end else begin
         if (full_q && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (req_fire && (fetch_cnt != 32'hFFFF_FFFF)) begin
            fetch_cnt <= fetch_cnt + 32'd1;
         end
      end
   end

   assign perf_stall_cycles = stall_cnt;
   assign perf_fetches      = fetch_cnt;
`else
   assign perf_stall_cycles = 32'd0;
   assign perf_fetches      = 32'd0;
`endif

endmodule

// File: tb/tb_control_stage3_occ_fetch.sv
// tb/tb_control_stage3_occ_fetch.sv - scoreboard bench for control_stage3_occ_fetch

module tb_control_stage3_occ_fetch;

   localparam logic [5:0]  ST_INI   = 6'b001000;
   localparam logic [5:0]  ST_RUN   = 6'b010000;
   localparam logic [63:0] MEM_BASE = 64'h1000;

   logic         clk = 1'b0;
   logic         rst;
   logic [5:0]   status_q;
   logic [8:0]   read_num_q;
   logic [6:0]   backward_i_q, backward_j_q, current_rd_addr_q;
   logic [63:0]  primary_q;
   logic         finish_sign_q, iteration_boundary_q;
   logic [63:0]  mem_base;
   logic         stall_out, req_valid, req_ready;
   logic [63:0]  req_addr;
   logic         rsp_valid;
   logic [511:0] rsp_data;
   logic         out_stall, out_valid;
   logic [5:0]   out_status;
   logic [8:0]   out_read_num;
   logic [6:0]   out_backward_i, out_backward_j, out_rd_addr;
   logic [63:0]  out_primary;
   logic         out_finish_sign, out_iteration_boundary;
   logic [511:0] out_occ_line;
   logic         err_orphan_rsp;
   logic [31:0]  perf_stall_cycles, perf_fetches;

   control_stage3_occ_fetch #(.DEPTH(8), .PTR_W(3)) dut (
      .clk(clk), .rst(rst),
      .status_q(status_q), .read_num_q(read_num_q),
      .backward_i_q(backward_i_q), .backward_j_q(backward_j_q),
      .current_rd_addr_q(current_rd_addr_q), .primary_q(primary_q),
      .finish_sign_q(finish_sign_q), .iteration_boundary_q(iteration_boundary_q),
      .mem_base(mem_base), .stall_out(stall_out),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .out_stall(out_stall), .out_valid(out_valid), .out_status(out_status),
      .out_read_num(out_read_num), .out_backward_i(out_backward_i),
      .out_backward_j(out_backward_j), .out_rd_addr(out_rd_addr),
      .out_primary(out_primary), .out_finish_sign(out_finish_sign),
      .out_iteration_boundary(out_iteration_boundary), .out_occ_line(out_occ_line),
      .err_orphan_rsp(err_orphan_rsp),
      .perf_stall_cycles(perf_stall_cycles), .perf_fetches(perf_fetches)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [101:0] hdr;
      logic [511:0] line;
   } tok_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int mem_delay = 3;
   int req_seen = 0;
   int out_count = 0;
   bit ready_en = 1'b1;
   bit inject_orphan = 1'b0;
   logic [63:0] last_req_addr = 64'd0;

   tok_t        exp_q[$];
   logic [63:0] exp_req_q[$];
   logic [63:0] pend_addr[$];
   int          pend_due[$];

   task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [511:0] mem_line(input logic [63:0] a);
      return {8{a ^ 64'hA5A5_A5A5_A5A5_A5A5}};
   endfunction

   function automatic logic [101:0] out_hdr();
      return {out_status, out_read_num, out_backward_i, out_backward_j, out_rd_addr,
              out_primary, out_finish_sign, out_iteration_boundary};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // memory model: in-order responses mem_delay cycles after each handshake
   always @(negedge clk) begin
      #1;
      if (rst) begin
         rsp_valid = 1'b0;
         req_ready = 1'b0;
         pend_addr.delete();
         pend_due.delete();
      end else begin
         rsp_valid = 1'b0;
         rsp_data  = '0;
         if (inject_orphan) begin
            rsp_valid     = 1'b1;
            rsp_data      = {64{8'h5A}};
            inject_orphan = 1'b0;
         end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_line(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end
         req_ready = ready_en;
         if (req_valid) req_seen++;
         if (req_valid && req_ready) begin
            if (exp_req_q.size() == 0) begin
               check("unexpected_req", 1'b1, 1'b0);
            end else begin
               check("req_addr", req_addr, exp_req_q.pop_front());
            end
            last_req_addr = req_addr;
            pend_addr.push_back(req_addr);
            pend_due.push_back(cyc + mem_delay);
         end
      end
   end

   // output monitor: every consumed output is popped from the scoreboard,
   // and a stalled output must hold until the stall lifts.
   tok_t held;
   bit   held_valid = 1'b0;
   always @(negedge clk) begin
      #1;
      if (!rst && out_valid) begin
         if (held_valid) begin
            check("hold_hdr", out_hdr(), held.hdr);
            check("hold_line", out_occ_line, held.line);
         end
         if (out_stall) begin
            held.hdr   = out_hdr();
            held.line  = out_occ_line;
            held_valid = 1'b1;
         end else begin
            held_valid = 1'b0;
            out_count++;
            if (exp_q.size() == 0) begin
               check("unexpected_out", 1'b1, 1'b0);
            end else begin
               tok_t e;
               e = exp_q.pop_front();
               check("out_hdr", out_hdr(), e.hdr);
               check("out_occ_line", out_occ_line, e.line);
            end
         end
      end else begin
         held_valid = 1'b0;
      end
   end

   // Present one token at a negedge and keep it until captured.
   task automatic send(input logic [5:0] st, input logic [8:0] rn, input logic [63:0] pr);
      tok_t e;
      int   n = 0;
      logic [63:0] a;
      status_q             = st;
      read_num_q           = rn;
      backward_i_q         = rn[6:0];
      backward_j_q         = ~rn[6:0];
      current_rd_addr_q    = rn[6:0] + 7'd3;
      primary_q            = pr;
      finish_sign_q        = rn[0];
      iteration_boundary_q = rn[1];
      while (stall_out && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("send_timeout", n < 200, 1'b1);
      a      = MEM_BASE + (pr >> 7);
      e.hdr  = {st, rn, rn[6:0], ~rn[6:0], rn[6:0] + 7'd3, pr, rn[0], rn[1]};
      e.line = (st == ST_RUN) ? mem_line(a) : 512'd0;
      exp_q.push_back(e);
      if (st == ST_RUN) exp_req_q.push_back(a);
      @(negedge clk);
      status_q = 6'd0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(nm, n < 300, 1'b1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_cnt;
      int n;
      rst = 1'b1;
      status_q = 0; read_num_q = 0; backward_i_q = 0; backward_j_q = 0;
      current_rd_addr_q = 0; primary_q = 0; finish_sign_q = 0;
      iteration_boundary_q = 0; mem_base = MEM_BASE; out_stall = 0;
      req_ready = 0; rsp_valid = 0; rsp_data = '0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_status", out_status, 6'd0);
      check("rst_stall_out", stall_out, 1'b0);
      check("rst_req_valid", req_valid, 1'b0);
      check("rst_err", err_orphan_rsp, 1'b0);
      check("rst_perf", {perf_stall_cycles, perf_fetches}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // one BCK_INI: visible two edges after presentation, no request
      req_seen = 0;
      send(ST_INI, 9'd5, 64'h77);
      check("ini_latency_early", out_valid, 1'b0);
      @(negedge clk);
      check("ini_latency_valid", out_valid, 1'b1);
      check("ini_status", out_status, ST_INI);
      check("ini_line", out_occ_line, 512'd0);
      wait_idle("ini_drain");
      check("ini_no_req", req_seen, 0);

      // BCK_RUN address computation and line return
      mem_delay = 3;
      send(ST_RUN, 9'd17, 64'h1_0080);
      wait_idle("run_drain");
      check("run_req_addr", last_req_addr, 64'h1201);

      // fill the buffer with requests blocked, then a held ninth token
      ready_en = 1'b0;
      base_cnt = out_count;
      for (int i = 0; i < 8; i++) send(ST_RUN, 9'(40 + i), 64'h100 * (i + 1));
      check("full_stall", stall_out, 1'b1);
      fork
         send(ST_INI, 9'd99, 64'h5);
         begin
            repeat (4) @(negedge clk);
            check("full_hold_stall", stall_out, 1'b1);
            ready_en = 1'b1;
         end
      join
      wait_idle("full_drain");
      check("full_out_count", out_count - base_cnt, 9);

      // RUN, INI, RUN with slow memory: INI must wait behind the first RUN
      mem_delay = 6;
      send(ST_RUN, 9'd201, 64'hABC0);
      send(ST_INI, 9'd202, 64'h1234);
      send(ST_RUN, 9'd203, 64'hFFFF_FFFF_FFFF_FF80);
      wait_idle("order_drain");

      // output held across a 5-cycle downstream stall
      out_stall = 1'b1;
      send(ST_INI, 9'd300, 64'h42);
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      check("stall_out_valid", out_valid, 1'b1);
      repeat (5) @(negedge clk);
      out_stall = 1'b0;
      wait_idle("stall_drain");

      // orphan response sets a sticky flag
      check("orphan_pre", err_orphan_rsp, 1'b0);
      inject_orphan = 1'b1;
      repeat (2) @(negedge clk);
      check("orphan_set", err_orphan_rsp, 1'b1);
      repeat (5) @(negedge clk);
      check("orphan_sticky", err_orphan_rsp, 1'b1);

      // reset with tokens buffered and requests outstanding
      mem_delay = 40;
      send(ST_RUN, 9'd401, 64'h8000);
      send(ST_RUN, 9'd402, 64'h9000);
      send(ST_INI, 9'd403, 64'h1);
      n = 0;
      while (pend_addr.size() < 2 && n < 20) begin @(negedge clk); n++; end
      check("rst_outstanding", pend_addr.size(), 2);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_status", out_status, 6'd0);
      check("mid_rst_req_valid", req_valid, 1'b0);
      check("mid_rst_req_addr", req_addr, 64'd0);
      check("mid_rst_err", err_orphan_rsp, 1'b0);
      check("mid_rst_stall", stall_out, 1'b0);
      check("mid_rst_line", out_occ_line, 512'd0);
      exp_q.delete();
      exp_req_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      mem_delay = 3;
      send(ST_INI, 9'd500, 64'h3);
      wait_idle("post_rst_drain");
      check("post_rst_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
